// File: rtl/tfe_mac_engine_if.sv
// Valid/ready stream bundle for tfe_mac_engine: weight in, activation in, result beats out.
// The master modport is the stream source/sink side; the engine uses the slave modport.
interface tfe_mac_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;

  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] a_data;

  logic              res_valid;
  logic              res_ready;
  logic [OUT_W-1:0]  res_data;
  logic              res_last;

  modport master (
    output w_valid, w_data, a_valid, a_data, res_ready,
    input  w_ready, a_ready, res_valid, res_data, res_last
  );

  modport slave (
    input  w_valid, w_data, a_valid, a_data, res_ready,
    output w_ready, a_ready, res_valid, res_data, res_last
  );
endinterface

// File: rtl/tfe_mac_engine.sv
// Signed dot-product engine: DEPTH-entry weight buffer, streamed activations, OUT_W-bit result beats.
// Define TFE_RELU_EN to clamp negative sums to zero before they are emitted.
module tfe_mac_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rts,
  input  logic                   clear,
  tfe_mac_engine_if.slave        bus,
  output logic                   weights_loaded,
  output logic                   busy
);

  localparam int NB     = (ACC_W + OUT_W - 1) / OUT_W;
  localparam int RES_W  = NB * OUT_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          wptr_q, idx_q;
  logic [BEAT_W-1:0]         beat_q;
  logic signed [ACC_W-1:0]   acc_q, acc_next;
  logic [RES_W-1:0]          result_q, result_d;
  logic                      loaded_q;
  logic [DATA_W-1:0]         wbuf [DEPTH];

  logic                      w_ready_c, a_ready_c, res_valid_c;
  logic                      w_fire, a_fire, r_fire;
  logic signed [PROD_W-1:0]  a_ext, w_ext, prod;

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake readies
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    w_ready_c   = 1'b0;
    a_ready_c   = 1'b0;
    res_valid_c = 1'b0;
    case (state_q)
      S_LOAD: begin
        w_ready_c = 1'b1;
        if (bus.w_valid && wptr_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        a_ready_c = 1'b1;
        if (bus.a_valid && idx_q == LAST_IDX) state_d = S_RUN == S_RUN ? S_OUT : S_RUN;
      end
      S_OUT: begin
        res_valid_c = 1'b1;
        if (bus.res_ready && beat_q == LAST_BEAT) state_d = S_RUN;
      end
      default: state_d = S_LOAD;
    endcase
    if (clear) state_d = S_LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rts) begin
    if (!rts) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  // clear overrides every handshake in the cycle it is asserted
  assign w_fire = bus.w_valid & w_ready_c   & ~clear;
  assign a_fire = bus.a_valid & a_ready_c   & ~clear;
  assign r_fire = bus.res_ready & res_valid_c & ~clear;

  // ---------------------------------------------------------------------------
  // Multiply-accumulate
  // ---------------------------------------------------------------------------
  assign a_ext    = PROD_W'($signed(bus.a_data));
  assign w_ext    = PROD_W'($signed(wbuf[idx_q]));
  assign prod     = a_ext * w_ext;
  assign acc_next = acc_q + ACC_W'(prod);

`ifdef TFE_RELU_EN
  assign result_d = acc_next[ACC_W-1] ? '0 : RES_W'(acc_next);
`else
  assign result_d = RES_W'(acc_next);
`endif

  // NOTE: the weight buffer has no reset; its contents survive rts and clear,
  // and only written entries are ever read.
  always_ff @(posedge clk) begin
    if (w_fire) wbuf[wptr_q] <= bus.w_data;
  end

  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      wptr_q   <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      loaded_q <= 1'b0;
    end else if (clear) begin
      wptr_q   <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      if (w_fire) begin
        if (wptr_q == LAST_IDX) begin
          wptr_q   <= '0;
          loaded_q <= 1'b1;
        end else begin
          wptr_q <= wptr_q + 1'b1;
        end
      end

      if (a_fire) begin
        acc_q <= acc_next;
        if (idx_q == LAST_IDX) begin
          idx_q    <= '0;
          beat_q   <= '0;
          result_q <= result_d;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end

      if (r_fire) begin
        if (beat_q == LAST_BEAT) begin
          beat_q <= '0;
          acc_q  <= '0;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.w_ready   = w_ready_c;
  assign bus.a_ready   = a_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.res_data  = (state_q == S_OUT) ? result_q[int'(beat_q) * OUT_W +: OUT_W] : '0;
  assign bus.res_last  = (state_q == S_OUT) && (beat_q == LAST_BEAT);

  assign weights_loaded = loaded_q;
  assign busy           = ((state_q == S_RUN) && (idx_q != '0)) || (state_q == S_OUT);

endmodule

// File: tb/tb_tfe_mac_engine.sv
// Directed plus randomized bench for tfe_mac_engine against a plain-arithmetic dot-product model.
// Build with +define+TFE_RELU_EN to check the ReLU variant.
module tb_tfe_mac_engine;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int NB     = (ACC_W + OUT_W - 1) / OUT_W;

  logic clk = 1'b0;
  logic rts;
  logic clear;
  logic weights_loaded;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  byte w_cur [DEPTH];
  byte a_cur [DEPTH];

  tfe_mac_engine_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  tfe_mac_engine #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .OUT_W(OUT_W)
  ) dut (
    .clk            (clk),
    .rts            (rts),
    .clear          (clear),
    .bus            (bus),
    .weights_loaded (weights_loaded),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: dot product of signed bytes, optionally clamped at zero.
  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < DEPTH; i++) s += longint'(w_cur[i]) * longint'(a_cur[i]);
`ifdef TFE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic logic [7:0] beat_of(input longint s, input int k);
    longint sh;
    sh = s >>> (8 * k);
    return 8'(sh);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_ready"},   32'(bus.w_ready),      32'd1);
    check({tag, "_a_ready"},   32'(bus.a_ready),      32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid),    32'd0);
    check({tag, "_res_data"},  32'(bus.res_data),     32'd0);
    check({tag, "_res_last"},  32'(bus.res_last),     32'd0);
    check({tag, "_loaded"},    32'(weights_loaded),   32'd0);
    check({tag, "_busy"},      32'(busy),             32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_weights(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      int n = 0;
      bus.w_valid = 1'b1;
      bus.w_data  = w_cur[i];
      while (bus.w_ready !== 1'b1 && n < 20) begin tick(); n++; end
      if (n == 20) check({tag, "_w_ready_timeout"}, 32'(bus.w_ready), 32'd1);
      tick();
    end
    bus.w_valid = 1'b0;
    check({tag, "_loaded"},      32'(weights_loaded), 32'd1);
    check({tag, "_a_ready_run"}, 32'(bus.a_ready),    32'd1);
    check({tag, "_w_ready_run"}, 32'(bus.w_ready),    32'd0);
  endtask

  task automatic send_acts(input string tag, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      int n = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.a_valid = 1'b0;
        bus.a_data  = 8'($urandom);
        tick();
      end
      bus.a_valid = 1'b1;
      bus.a_data  = a_cur[i];
      while (bus.a_ready !== 1'b1 && n < 20) begin tick(); n++; end
      if (n == 20) check({tag, "_a_ready_timeout"}, 32'(bus.a_ready), 32'd1);
      tick();
      if (i == 0 && count > 1) check({tag, "_busy_run"}, 32'(busy), 32'd1);
    end
    bus.a_valid = 1'b0;
  endtask

  task automatic run_vector(input string tag, input bit gaps);
    send_acts(tag, DEPTH, gaps);
    check({tag, "_res_valid_latency"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_a_ready_out"},       32'(bus.a_ready),   32'd0);
    check({tag, "_busy_out"},          32'(busy),          32'd1);
  endtask

  task automatic collect_result(input string tag, input bit stall);
    longint s;
    s = model_sum();
    for (int k = 0; k < NB; k++) begin
      if (stall) begin
        int hold;
        hold = $urandom_range(0, 3);
        bus.res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
          tick();
          check($sformatf("%s_hold_valid%0d", tag, k), 32'(bus.res_valid), 32'd1);
          check($sformatf("%s_hold_data%0d", tag, k),  32'(bus.res_data),  32'(beat_of(s, k)));
        end
      end
      check($sformatf("%s_beat%0d", tag, k), 32'(bus.res_data), 32'(beat_of(s, k)));
      check($sformatf("%s_last%0d", tag, k), 32'(bus.res_last), 32'(k == NB - 1));
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
    end
    check({tag, "_res_valid_done"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_a_ready_done"},   32'(bus.a_ready),   32'd1);
    check({tag, "_busy_done"},      32'(busy),          32'd0);
  endtask

  task automatic fill(input byte wv, input byte av);
    for (int i = 0; i < DEPTH; i++) begin
      w_cur[i] = wv;
      a_cur[i] = av;
    end
  endtask

  initial begin
    rts = 1'b0;
    clear = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.a_valid = 1'b0;
    bus.a_data = '0;
    bus.res_ready = 1'b0;

    // T1: reset state
    repeat (3) tick();
    check_reset_outputs("t1");
    rts = 1'b1;
    tick();
    check_reset_outputs("t1_rel");

    // T2: ones against 1..16
    fill(8'sh01, 8'sh00);
    for (int i = 0; i < DEPTH; i++) a_cur[i] = byte'(i + 1);
    load_weights("t2");
    run_vector("t2", 1'b0);
    collect_result("t2", 1'b0);

    // T5: second vector on the retained T2 weights
    fill(8'sh01, 8'sh01);
    run_vector("t5", 1'b1);
    collect_result("t5", 1'b0);

    // T3: negative sum
    do_clear();
    fill(-8'sh01, 8'sh02);
    load_weights("t3");
    run_vector("t3", 1'b0);
    collect_result("t3", 1'b1);

    // T4: extreme operands, then a 5-cycle stall on beat 0
    do_clear();
    fill(-8'sh80, -8'sh80);
    load_weights("t4");
    run_vector("t4", 1'b0);
    bus.res_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      tick();
      check("t4_stall_valid", 32'(bus.res_valid), 32'd1);
      check("t4_stall_data",  32'(bus.res_data),  32'(beat_of(model_sum(), 0)));
      check("t4_stall_last",  32'(bus.res_last),  32'd0);
    end
    collect_result("t4", 1'b0);

    // T6: clear after 7 activations with a_valid high in the clear cycle
    do_clear();
    fill(8'sh01, 8'sh00);
    for (int i = 0; i < DEPTH; i++) a_cur[i] = byte'(i + 1);
    load_weights("t6");
    send_acts("t6", 7, 1'b0);
    bus.a_valid = 1'b1;
    bus.a_data  = 8'h7f;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.a_valid = 1'b0;
    check_reset_outputs("t6_clear");
    load_weights("t6r");
    run_vector("t6r", 1'b0);
    collect_result("t6r", 1'b0);

    // Randomized rounds: fresh weights, several vectors each
    for (int r = 0; r < 6; r++) begin
      do_clear();
      for (int i = 0; i < DEPTH; i++) w_cur[i] = byte'($urandom);
      if (r == 0) for (int i = 0; i < DEPTH; i++) w_cur[i] = (i % 2 == 0) ? -8'sh80 : 8'sh7f;
      load_weights($sformatf("rnd%0d", r));
      for (int v = 0; v < 3; v++) begin
        for (int i = 0; i < DEPTH; i++) a_cur[i] = byte'($urandom);
        run_vector($sformatf("rnd%0d_%0d", r, v), 1'b1);
        collect_result($sformatf("rnd%0d_%0d", r, v), 1'b1);
      end
    end

    // Reset pulse while in OUT
    for (int i = 0; i < DEPTH; i++) a_cur[i] = byte'($urandom);
    run_vector("rst_out", 1'b0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    #2 rts = 1'b0;
    #1;
    check_reset_outputs("rst_out");
    tick();
    rts = 1'b1;
    tick();
    check_reset_outputs("rst_out_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
